// File: rtl/rf_pkg.sv
// Shared types and default widths for the multi-port register file and its dump sequencer.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SWEEP = ST_SWEEP,
    DONE  = ST_DONE
  } dump_state_t;

endpackage

// File: rtl/rf_dump_seq.sv
// Dump sequencer: walks every register address once, one beat per accepted handshake.
//   state | meaning
//   IDLE  | waiting for dump_req
//   SWEEP | presenting beat idx, advancing on dump_ready
//   DONE  | one-cycle completion pulse, then back to IDLE
module rf_dump_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign dump_valid = (state_q == SWEEP);
  assign dump_done  = (state_q == DONE);
  assign dump_busy  = (state_q != IDLE);
  assign dump_addr  = idx_q;

endmodule

// File: rtl/regfile_mp_dump.sv
// Two-read / two-write register file with hard-wired zero register and a streaming dump port.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp_dump
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NPORT = 3;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [ADDR_W-1:0] port_addr [NPORT];
  logic [DATA_W-1:0] port_data [NPORT];

  // Port 1 is applied last so it wins an address collision.
  always_comb begin
    regs_d = regs_q;
    if (we0) regs_d[wa0] = wd0;
    if (we1) regs_d[wa1] = wd1;
    if (ZERO_REG != 0) regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  rf_dump_seq #(
    .ADDR_W (ADDR_W)
  ) u_dump_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_addr  (dump_addr)
  );

  assign port_addr[0] = rd_addr1;
  assign port_addr[1] = rd_addr2;
  assign port_addr[2] = dump_addr;

  // The dump port shares the read path so it sees the same forwarding and zero rules.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      port_data[p] = regs_q[port_addr[p]];
`ifdef RF_BYPASS_EN
      if (we0 && (wa0 == port_addr[p])) port_data[p] = wd0;
      if (we1 && (wa1 == port_addr[p])) port_data[p] = wd1;
`endif
      if ((ZERO_REG != 0) && (port_addr[p] == '0)) port_data[p] = '0;
    end
  end

  assign rd_data1  = port_data[0];
  assign rd_data2  = port_data[1];
  assign dump_data = port_data[2];

endmodule

// File: tb/tb_regfile_mp_dump.sv
// Self-checking bench for regfile_mp_dump: directed cases plus randomized traffic vs an array model.
module tb_regfile_mp_dump;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr1, rd_addr2, wa0, wa1, dump_addr;
  logic [DW-1:0] rd_data1, rd_data2, wd0, wd1, dump_data;
  logic          we0, we1, dump_req, dump_busy, dump_valid, dump_ready, dump_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  regfile_mp_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr1   (rd_addr1),
    .rd_data1   (rd_data1),
    .rd_addr2   (rd_addr2),
    .rd_data2   (rd_data2),
    .we0        (we0),
    .wa0        (wa0),
    .wd0        (wd0),
    .we1        (we1),
    .wa1        (wa1),
    .wd1        (wd1),
    .dump_req   (dump_req),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int a);
    logic [DW-1:0] v;
    v = mem[a];
`ifdef RF_BYPASS_EN
    if (we0 && int'(wa0) == a) v = wd0;
    if (we1 && int'(wa1) == a) v = wd1;
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  // Model update uses the inputs as they stand just before the edge.
  task automatic tick();
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else begin
      if (we0 && wa0 != 0) mem[wa0] = wd0;
      if (we1 && wa1 != 0) mem[wa1] = wd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
  endtask

  // st: 0 idle, 1 sweeping, 2 done pulse
  task automatic run_sweep(input bit rand_mode, input int abort_idx);
    int exp_idx;
    int st;
    int done_pulses;
    bit ph;
    bit finished;
    dump_req = 1'b1;
    dump_ready = 1'b0;
    #1;
    check("pre_busy", {31'd0, dump_busy}, 32'd0);
    tick();
    dump_req = 1'b0;
    exp_idx = 0; st = 1; done_pulses = 0; ph = 1'b1; finished = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      dump_ready = rand_mode ? 1'($urandom_range(0, 1)) : ph;
      ph = ~ph;
      if (rand_mode) begin
        we0 = 1'($urandom); we1 = 1'($urandom);
        wa0 = AW'($urandom); wd0 = $urandom; wd1 = $urandom;
        wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
        if ($urandom_range(0, 2) == 0) wa0 = AW'(exp_idx);
        rd_addr1 = AW'($urandom); rd_addr2 = AW'($urandom);
        dump_req = (st != 0) ? 1'($urandom) : 1'b0;
      end
      if (st == 1 && exp_idx == abort_idx) rst_n = 1'b0;
      #1;
      check("dump_valid", {31'd0, dump_valid}, (st == 1) ? 32'd1 : 32'd0);
      check("dump_busy",  {31'd0, dump_busy},  (st != 0) ? 32'd1 : 32'd0);
      check("dump_done",  {31'd0, dump_done},  (st == 2) ? 32'd1 : 32'd0);
      done_pulses += int'(dump_done);
      if (rand_mode) begin
        check("sweep_rd1", rd_data1, exp_rd(int'(rd_addr1)));
        check("sweep_rd2", rd_data2, exp_rd(int'(rd_addr2)));
      end
      if (st == 1) begin
        check("dump_addr", {27'd0, dump_addr}, DW'(exp_idx));
        check("dump_data", dump_data, exp_rd(exp_idx));
        if (!rand_mode)
          check("dump_lit", dump_data, (exp_idx == 0) ? 32'd0 : DW'(exp_idx + 1));
      end
      if (st == 0) finished = 1'b1;
      else if (!rst_n) st = 0;
      else if (st == 2) st = 0;
      else if (dump_ready) begin
        if (exp_idx == DEPTH - 1) st = 2;
        else exp_idx++;
      end
      if (!finished) tick();
      rst_n = 1'b1;
    end
    check("sweep_finished", {31'd0, finished}, 32'd1);
    check("done_pulses", DW'(done_pulses), (abort_idx < 0) ? 32'd1 : 32'd0);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(DEPTH - 1 - a);
      #1;
      check("rst_rd1", rd_data1, 32'd0);
      check("rst_rd2", rd_data2, 32'd0);
    end
    check("rst_busy",  {31'd0, dump_busy},  32'd0);
    check("rst_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_done",  {31'd0, dump_done},  32'd0);
    check("rst_addr",  {27'd0, dump_addr},  32'd0);

    // write collision: port 1 wins
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAAAA_0000;
    we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h5555_1111;
    tick();
    idle_inputs();
    rd_addr1 = 5'd3;
    #1;
    check("collide", rd_data1, 32'h5555_1111);

    // zero register drops writes
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    rd_addr2 = 5'd0;
    #1;
    check("zero_reg", rd_data2, 32'd0);

    // same-cycle write and read
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_1234;
    rd_addr1 = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    check("same_cycle", rd_data1, 32'h0000_1234);
`else
    check("same_cycle", rd_data1, 32'd0);
`endif
    tick();
    idle_inputs();
    #1;
    check("next_cycle", rd_data1, 32'h0000_1234);

    // load reg k = k+1 over both ports, then dump with ready toggling
    for (int k = 1; k < DEPTH; k += 2) begin
      we0 = 1'b1; wa0 = AW'(k); wd0 = DW'(k + 1);
      we1 = (k + 1 < DEPTH); wa1 = AW'(k + 1); wd1 = DW'(k + 2);
      tick();
    end
    idle_inputs();
    run_sweep(1'b0, -1);

    // reset mid-sweep, then fresh sweep from address 0 with live traffic
    run_sweep(1'b1, 10);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr1 = AW'(a);
      #1;
      check("abort_clear", rd_data1, 32'd0);
    end
    run_sweep(1'b1, -1);

    // randomized read/write traffic concentrated on a few addresses
    for (int n = 0; n < 150; n++) begin
      we0 = 1'($urandom); we1 = 1'($urandom);
      wa0 = AW'($urandom_range(0, 7)); wa1 = AW'($urandom_range(0, 7));
      wd0 = $urandom; wd1 = $urandom;
      rd_addr1 = AW'($urandom_range(0, 7)); rd_addr2 = AW'($urandom);
      #1;
      check("rand_rd1", rd_data1, exp_rd(int'(rd_addr1)));
      check("rand_rd2", rd_data2, exp_rd(int'(rd_addr2)));
      tick();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
